// File: rtl/eif_pkg.sv
// eif_pkg
// Shared types and default constants for the time-multiplexed EIF neuron
// scheduler.
//   fsm_e      : scheduler phase (IDLE accepts current injections, SWEEP updates neurons)
//   eif_val_t  : 8-bit membrane state / threshold value
//   EIF_THR_*  : default threshold ceiling, floor and spike decrement
//   sat_add    : 8-bit unsigned add clamped at 255
package eif_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } fsm_e;

    typedef logic [7:0] eif_val_t;

    localparam int EIF_THR_INIT = 200;
    localparam int EIF_THR_MIN  = 20;
    localparam int EIF_THR_DEC  = 10;

    // Saturating add: the ninth sum bit flags overflow past 255.
    function automatic eif_val_t sat_add(input eif_val_t a, input eif_val_t b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter: grants at most one requester per cycle, searching from
// the requester after the last one granted. A grant is only issued for a
// valid request, so every grant is an accepted transfer and moves the pointer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer back to 0)
//   en         : arbitration allowed this cycle
//   req        : request vector
//   grant      : one-hot grant (combinational)
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;

    // Walk the candidates from farthest to nearest so the nearest valid
    // requester after the pointer is the one left standing.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        if (en) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (req[PTR_W'((int'(ptr_q) + k) % NUM_REQ)]) begin
                    grant = '0;
                    grant[PTR_W'((int'(ptr_q) + k) % NUM_REQ)] = 1'b1;
                    ptr_d = PTR_W'((int'(ptr_q) + k + 1) % NUM_REQ);
                end
            end
        end
    end

    // Pointer register: holds the highest-priority requester for next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/neuron_scheduler.sv
// neuron_scheduler
// Time-multiplexed integrate-and-fire neuron bank. Between timesteps the
// block accepts current injections from NUM_REQ requesters (round-robin,
// one per cycle). A tick starts a sweep that visits one neuron per cycle,
// fires those at or above their adaptive threshold and relaxes the others.
// Optional build macro:
//   EIF_LEAK_EN : non-spiking visited neurons also leak one unit of state.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_valid    : per-requester injection request
//   req_idx      : packed target neuron per requester (requester 0 in LSBs)
//   req_current  : packed 8-bit unsigned current per requester
//   req_ready    : one-hot grant, transfer on valid & ready
//   tick         : timestep strobe, starts (or queues) an update sweep
//   spike_valid  : registered one-cycle spike pulse
//   spike_idx    : index of the spiking neuron
//   busy         : high while sweeping
module neuron_scheduler
    import eif_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int NUM_NEURONS = 8,
    parameter int THR_INIT    = EIF_THR_INIT,
    parameter int THR_MIN     = EIF_THR_MIN,
    parameter int THR_DEC     = EIF_THR_DEC,
    localparam int IDX_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_idx,
    input  logic [NUM_REQ*8-1:0]     req_current,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     tick,
    output logic                     spike_valid,
    output logic [IDX_W-1:0]         spike_idx,
    output logic                     busy
);

    fsm_e             fsm_q, fsm_d;
    logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
    logic             pending_q, pending_d;
    logic             spike_valid_q, spike_valid_d;
    logic [IDX_W-1:0] spike_idx_q, spike_idx_d;
    eif_val_t         state_q [NUM_NEURONS];
    eif_val_t         state_d [NUM_NEURONS];
    eif_val_t         thr_q   [NUM_NEURONS];
    eif_val_t         thr_d   [NUM_NEURONS];

    logic             arb_en;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0] sel_idx;
    eif_val_t         sel_cur;
    eif_val_t         cur_state;
    eif_val_t         cur_thr;

    // Injections are only taken in a quiet IDLE cycle: a tick (new or queued)
    // takes priority so the sweep sees a stable snapshot.
    assign arb_en = (fsm_q == IDLE) && !tick && !pending_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   (req_valid),
        .grant (grant)
    );

    assign req_ready   = grant;
    assign busy        = (fsm_q == SWEEP);
    assign spike_valid = spike_valid_q;
    assign spike_idx   = spike_idx_q;

    // Mux out the target index and current of the granted requester.
    always_comb begin
        sel_idx = '0;
        sel_cur = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant[r]) begin
                sel_idx = req_idx[r*IDX_W +: IDX_W];
                sel_cur = req_current[r*8 +: 8];
            end
        end
    end

    // Next-state logic: injection in IDLE, one neuron update per SWEEP cycle.
    always_comb begin
        fsm_d         = fsm_q;
        sweep_idx_d   = sweep_idx_q;
        pending_d     = pending_q;
        spike_valid_d = 1'b0;
        spike_idx_d   = spike_idx_q;
        state_d       = state_q;
        thr_d         = thr_q;
        cur_state     = state_q[sweep_idx_q];
        cur_thr       = thr_q[sweep_idx_q];

        case (fsm_q)
            IDLE: begin
                if (tick || pending_q) begin
                    fsm_d       = SWEEP;
                    sweep_idx_d = '0;
                    pending_d   = 1'b0;
                end else if (|grant) begin
                    state_d[sel_idx] = sat_add(state_q[sel_idx], sel_cur);
                end
            end
            SWEEP: begin
                // Ticks during a sweep collapse into a single queued sweep.
                if (tick) begin
                    pending_d = 1'b1;
                end
                if (cur_state >= cur_thr) begin
                    spike_valid_d          = 1'b1;
                    spike_idx_d            = sweep_idx_q;
                    state_d[sweep_idx_q]   = cur_state - cur_thr;
                    thr_d[sweep_idx_q]     = (int'(cur_thr) >= THR_MIN + THR_DEC)
                                           ? cur_thr - eif_val_t'(THR_DEC)
                                           : eif_val_t'(THR_MIN);
                end else begin
                    thr_d[sweep_idx_q]     = (int'(cur_thr) >= THR_INIT)
                                           ? eif_val_t'(THR_INIT)
                                           : cur_thr + 8'd1;
`ifdef EIF_LEAK_EN
                    state_d[sweep_idx_q]   = (cur_state != '0) ? cur_state - 8'd1 : '0;
`endif
                end
                if (sweep_idx_q == IDX_W'(NUM_NEURONS - 1)) begin
                    fsm_d = IDLE;
                end else begin
                    sweep_idx_d = sweep_idx_q + 1'b1;
                end
            end
        endcase
    end

    // State registers; reset aborts any sweep in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q         <= IDLE;
            sweep_idx_q   <= '0;
            pending_q     <= 1'b0;
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                state_q[n] <= '0;
                thr_q[n]   <= eif_val_t'(THR_INIT);
            end
        end else begin
            fsm_q         <= fsm_d;
            sweep_idx_q   <= sweep_idx_d;
            pending_q     <= pending_d;
            spike_valid_q <= spike_valid_d;
            spike_idx_q   <= spike_idx_d;
            state_q       <= state_d;
            thr_q         <= thr_d;
        end
    end

endmodule

// File: tb/tb_neuron_scheduler.sv
// tb_neuron_scheduler
// Self-checking bench for neuron_scheduler (default parameters). A behavioural
// model tracks neuron state, thresholds, arbitration and the sweep; spikes it
// predicts are queued and matched against the DUT spike output.
// Honours EIF_LEAK_EN in the same way as the design.
module tb_neuron_scheduler;

    localparam int NUM_REQ     = 4;
    localparam int NUM_NEURONS = 8;
    localparam int IDX_W       = 3;
    localparam int THR_INIT    = 200;
    localparam int THR_MIN     = 20;
    localparam int THR_DEC     = 10;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ*IDX_W-1:0] req_idx = '0;
    logic [NUM_REQ*8-1:0]     req_current = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     tick = 1'b0;
    logic                     spike_valid;
    logic [IDX_W-1:0]         spike_idx;
    logic                     busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference model
    int  m_state [NUM_NEURONS];
    int  m_thr   [NUM_NEURONS];
    bit  m_busy;
    bit  m_pending;
    int  m_idx;
    int  m_ptr;
    int  exp_q [$];
    int  mon_exp;

    neuron_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_idx     (req_idx),
        .req_current (req_current),
        .req_ready   (req_ready),
        .tick        (tick),
        .spike_valid (spike_valid),
        .spike_idx   (spike_idx),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int n = 0; n < NUM_NEURONS; n++) begin
            m_state[n] = 0;
            m_thr[n]   = THR_INIT;
        end
        m_busy    = 1'b0;
        m_pending = 1'b0;
        m_idx     = 0;
        m_ptr     = 0;
        exp_q.delete();
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_update();
        int  i;
        int  r;
        int  tgt;
        int  cur;
        bit  found;
        if (m_busy) begin
            i = m_idx;
            if (m_state[i] >= m_thr[i]) begin
                exp_q.push_back(i);
                m_state[i] = m_state[i] - m_thr[i];
                m_thr[i]   = (m_thr[i] - THR_DEC < THR_MIN) ? THR_MIN : m_thr[i] - THR_DEC;
            end else begin
                m_thr[i] = (m_thr[i] + 1 > THR_INIT) ? THR_INIT : m_thr[i] + 1;
`ifdef EIF_LEAK_EN
                if (m_state[i] > 0) m_state[i] = m_state[i] - 1;
`endif
            end
            if (tick) m_pending = 1'b1;
            if (i == NUM_NEURONS - 1) m_busy = 1'b0;
            else m_idx = m_idx + 1;
        end else if (tick || m_pending) begin
            m_busy    = 1'b1;
            m_idx     = 0;
            m_pending = 1'b0;
        end else begin
            found = 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                r = (m_ptr + k) % NUM_REQ;
                if (!found && (((req_valid >> r) & 4'd1) != 4'd0)) begin
                    found = 1'b1;
                    tgt = int'((req_idx >> (r * IDX_W)) & 12'h7);
                    cur = int'((req_current >> (r * 8)) & 32'hFF);
                    m_state[tgt] = (m_state[tgt] + cur > 255) ? 255 : m_state[tgt] + cur;
                    m_ptr = (r + 1) % NUM_REQ;
                end
            end
        end
    endtask

    function automatic logic [NUM_REQ-1:0] model_ready();
        int r;
        if (m_busy || tick || m_pending) return '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            r = (m_ptr + k) % NUM_REQ;
            if (((req_valid >> r) & 4'd1) != 4'd0) return NUM_REQ'(1 << r);
        end
        return '0;
    endfunction

    // One clock: model follows the rising edge, return at the falling edge.
    task automatic advance();
        @(posedge clk);
        if (rst_n) model_update();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        tick      = 1'b0;
        req_valid = '0;
        rst_n     = 1'b0;
        model_reset();
        repeat (2) advance();
        rst_n = 1'b1;
    endtask

    task automatic run_sweep();
        tick = 1'b1;
        advance();
        tick = 1'b0;
        repeat (NUM_NEURONS + 1) advance();
    endtask

    // Scoreboard: every spike pulse must match the next predicted spike, and
    // every predicted spike must appear on the cycle it was predicted for.
    always @(posedge clk) begin
        #1;
        if (spike_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL spike_unexpected: got idx %0d, expected no spike", spike_idx);
            end else begin
                mon_exp = exp_q.pop_front();
                if (int'(spike_idx) != mon_exp) begin
                    miscompares++;
                    $display("[TB] FAIL spike_idx: got %0d, expected %0d", spike_idx, mon_exp);
                end
            end
        end else if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            mon_exp = exp_q.pop_front();
            $display("[TB] FAIL spike_missing: got no spike, expected idx %0d", mon_exp);
        end
    end

    task automatic test_reset();
        int spikes;
        int grants;
        model_reset();
        @(negedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || spike_valid !== 1'b0 || spike_idx !== '0 || req_ready !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got busy=%b spike=%b idx=%0d ready=%b, expected all 0",
                     busy, spike_valid, spike_idx, req_ready);
        end
        for (int n = 0; n < NUM_NEURONS; n++) begin
            vectors++;
            if (dut.state_q[n] !== 8'd0 || dut.thr_q[n] !== 8'(THR_INIT)) begin
                miscompares++;
                $display("[TB] FAIL reset_neuron%0d: got state=%0d thr=%0d, expected 0/%0d",
                         n, dut.state_q[n], dut.thr_q[n], THR_INIT);
            end
        end
        rst_n = 1'b1;
        spikes = 0;
        grants = 0;
        for (int c = 0; c < 100; c++) begin
            advance();
            if (spike_valid !== 1'b0) spikes++;
            if (req_ready !== '0) grants++;
        end
        vectors++;
        if (spikes != 0 || grants != 0) begin
            miscompares++;
            $display("[TB] FAIL idle_quiet: got %0d spikes %0d grants, expected 0/0", spikes, grants);
        end
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] exp_grant [5];
        exp_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req_valid   = 4'hF;
        req_idx     = '0;
        req_current = {4{8'd1}};
        for (int k = 0; k < 5; k++) begin
            #1;
            vectors++;
            if (req_ready !== exp_grant[k]) begin
                miscompares++;
                $display("[TB] FAIL rr_grant%0d: got %b, expected %b", k, req_ready, exp_grant[k]);
            end
            advance();
            if (k == 3) begin
                vectors++;
                if (dut.state_q[0] !== 8'd4) begin
                    miscompares++;
                    $display("[TB] FAIL rr_state0: got %0d, expected 4", dut.state_q[0]);
                end
            end
        end
        req_valid = '0;
    endtask

    task automatic test_saturation_spike();
        int spike_cnt;
        int spike_at;
        int spike_id;
        req_valid   = 4'b0001;
        req_idx     = 12'd2;
        req_current = 32'd255;
        advance();
        req_current = 32'd10;
        advance();
        vectors++;
        if (dut.state_q[2] !== 8'd255) begin
            miscompares++;
            $display("[TB] FAIL sat_state2: got %0d, expected 255", dut.state_q[2]);
        end
        // Requester 3 holds a request across the tick and the whole sweep.
        req_valid   = 4'b1000;
        req_idx     = {3'd5, 9'd0};
        req_current = {8'd7, 24'd0};
        tick        = 1'b1;
        #1;
        vectors++;
        if (req_ready !== '0) begin
            miscompares++;
            $display("[TB] FAIL tick_ready: got %b, expected 0000", req_ready);
        end
        advance();
        tick = 1'b0;
        spike_cnt = 0;
        spike_at  = -1;
        spike_id  = -1;
        for (int s = 0; s < NUM_NEURONS; s++) begin
            #1;
            vectors++;
            if (busy !== 1'b1 || req_ready !== '0) begin
                miscompares++;
                $display("[TB] FAIL sweep_hold%0d: got busy=%b ready=%b, expected 1/0000", s, busy, req_ready);
            end
            advance();
            if (spike_valid === 1'b1) begin
                spike_cnt++;
                spike_at = s;
                spike_id = int'(spike_idx);
            end
        end
        vectors++;
        if (spike_cnt != 1 || spike_at != 2 || spike_id != 2) begin
            miscompares++;
            $display("[TB] FAIL sweep_spike: got count=%0d at=%0d idx=%0d, expected 1/2/2",
                     spike_cnt, spike_at, spike_id);
        end
        #1;
        vectors++;
        if (busy !== 1'b0 || req_ready !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL post_sweep_grant: got busy=%b ready=%b, expected 0/1000", busy, req_ready);
        end
        advance();
        req_valid = '0;
        vectors++;
        if (dut.state_q[2] !== 8'd55 || dut.thr_q[2] !== 8'd190 || dut.state_q[5] !== 8'd7) begin
            miscompares++;
            $display("[TB] FAIL spike_update: got s2=%0d t2=%0d s5=%0d, expected 55/190/7",
                     dut.state_q[2], dut.thr_q[2], dut.state_q[5]);
        end
    endtask

    task automatic test_back_to_back();
        int busy_cnt;
        req_idx     = '0;
        req_current = '0;
        tick        = 1'b1;
        advance();
        busy_cnt = 0;
        for (int j = 0; j < 30; j++) begin
            tick      = (j == 2 || j == 5);
            req_valid = (j == 8) ? 4'b0001 : 4'b0000;
            #1;
            if (busy === 1'b1) busy_cnt++;
            if (j == 8) begin
                vectors++;
                if (busy !== 1'b0 || req_ready !== '0) begin
                    miscompares++;
                    $display("[TB] FAIL pending_gap: got busy=%b ready=%b, expected 0/0000", busy, req_ready);
                end
            end
            advance();
        end
        tick      = 1'b0;
        req_valid = '0;
        vectors++;
        if (busy_cnt != 2 * NUM_NEURONS) begin
            miscompares++;
            $display("[TB] FAIL busy_cycles: got %0d, expected %0d", busy_cnt, 2 * NUM_NEURONS);
        end
    endtask

    task automatic test_threshold_recovery();
        int exp_s6;
`ifdef EIF_LEAK_EN
        exp_s6 = 0;
`else
        exp_s6 = 3;
`endif
        apply_reset();
        req_valid   = 4'b0001;
        req_idx     = 12'd1;
        req_current = 32'd200;
        advance();
        req_idx     = 12'd6;
        req_current = 32'd3;
        advance();
        req_valid = '0;
        for (int s = 0; s < 6; s++) run_sweep();
        vectors++;
        if (dut.thr_q[1] !== 8'd195 || dut.state_q[1] !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL thr_recover: got thr1=%0d s1=%0d, expected 195/0", dut.thr_q[1], dut.state_q[1]);
        end
        vectors++;
        if (dut.thr_q[6] !== 8'(THR_INIT) || dut.state_q[6] !== 8'(exp_s6)) begin
            miscompares++;
            $display("[TB] FAIL thr_ceiling_leak: got thr6=%0d s6=%0d, expected %0d/%0d",
                     dut.thr_q[6], dut.state_q[6], THR_INIT, exp_s6);
        end
    endtask

    task automatic test_threshold_floor();
        for (int k = 0; k < 20; k++) begin
            req_valid   = 4'b0001;
            req_idx     = 12'd7;
            req_current = 32'd255;
            advance();
            req_valid = '0;
            run_sweep();
        end
        vectors++;
        if (dut.thr_q[7] !== 8'(THR_MIN)) begin
            miscompares++;
            $display("[TB] FAIL thr_floor: got %0d, expected %0d", dut.thr_q[7], THR_MIN);
        end
        for (int n = 0; n < NUM_NEURONS; n++) begin
            vectors++;
            if (dut.state_q[n] !== 8'(m_state[n]) || dut.thr_q[n] !== 8'(m_thr[n])) begin
                miscompares++;
                $display("[TB] FAIL model_neuron%0d: got state=%0d thr=%0d, expected %0d/%0d",
                         n, dut.state_q[n], dut.thr_q[n], m_state[n], m_thr[n]);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int spikes;
        for (int n = 4; n < NUM_NEURONS; n++) begin
            req_valid   = 4'b0001;
            req_idx     = 12'(n);
            req_current = 32'd255;
            advance();
        end
        req_valid = '0;
        tick      = 1'b1;
        advance();
        tick = 1'b0;
        repeat (4) advance();
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (spike_valid !== 1'b0 || busy !== 1'b0 || spike_idx !== '0 || req_ready !== '0) begin
            miscompares++;
            $display("[TB] FAIL abort_outputs: got spike=%b busy=%b idx=%0d ready=%b, expected all 0",
                     spike_valid, busy, spike_idx, req_ready);
        end
        for (int n = 0; n < NUM_NEURONS; n++) begin
            vectors++;
            if (dut.state_q[n] !== 8'd0 || dut.thr_q[n] !== 8'(THR_INIT)) begin
                miscompares++;
                $display("[TB] FAIL abort_neuron%0d: got state=%0d thr=%0d, expected 0/%0d",
                         n, dut.state_q[n], dut.thr_q[n], THR_INIT);
            end
        end
        spikes = 0;
        repeat (3) begin
            advance();
            if (spike_valid !== 1'b0) spikes++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            advance();
            if (spike_valid !== 1'b0 || busy !== 1'b0) spikes++;
        end
        vectors++;
        if (spikes != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL abort_quiet: got %0d active cycles %0d queued, expected 0/0", spikes, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_saturation_spike();
        test_back_to_back();
        test_threshold_recovery();
        test_threshold_floor();
        test_reset_mid_sweep();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL spikes_outstanding: got %0d left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/neuron_scheduler.md
NEURON_SCHEDULER -- requirements
Module: neuron_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of current-injection requesters.
REQ-002 Parameter NUM_NEURONS, default 8: number of time-multiplexed virtual neurons; IDX_W = clog2(NUM_NEURONS).
REQ-003 Parameter THR_INIT, default 200: reset threshold value and threshold ceiling.
REQ-004 Parameter THR_MIN, default 20: threshold floor.
REQ-005 Parameter THR_DEC, default 10: threshold decrement applied on spike.
REQ-006 clk  input  1  clock, rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 req_valid  input  NUM_REQ  per-requester injection request.
REQ-009 req_idx  input  NUM_REQ*IDX_W  target neuron per requester, packed, requester 0 in LSBs.
REQ-010 req_current  input  NUM_REQ*8  unsigned current per requester, packed.
REQ-011 req_ready  output  NUM_REQ  one-hot grant; transfer occurs when valid&ready.
REQ-012 tick  input  1  single-cycle timestep strobe starting an update sweep.
REQ-013 spike_valid  output  1  registered one-cycle spike pulse.
REQ-014 spike_idx  output  IDX_W  neuron index of the spike; valid with spike_valid.
REQ-015 busy  output  1  high while state is SWEEP.

Function
REQ-016 Block SHALL hold per-neuron 8-bit state and 8-bit threshold in internal register arrays.
REQ-017 FSM states SHALL be IDLE and SWEEP; tick, or a pending tick, in IDLE -> SWEEP next cycle with sweep index 0.
REQ-018 In IDLE with no tick and no pending tick, a round-robin arbiter SHALL grant one valid requester per cycle, priority starting after the last granted requester.
REQ-019 req_ready SHALL be combinational from req_valid and arbiter pointer, zero in SWEEP and in any cycle tick is high.
REQ-020 On transfer, state[idx] SHALL become min(state[idx]+current, 255), saturating.
REQ-021 SWEEP SHALL visit neuron i at sweep index i, one neuron per cycle, returning to IDLE after index NUM_NEURONS-1 (latency NUM_NEURONS cycles).
REQ-022 Visited neuron with state >= threshold SHALL: assert spike_valid and spike_idx=i next cycle, state <= state - threshold, threshold <= max(threshold - THR_DEC, THR_MIN).
REQ-023 Visited neuron with state < threshold SHALL: threshold <= min(threshold+1, THR_INIT).
REQ-024 tick arriving during SWEEP SHALL set a single pending flag (further ticks merge); pending SHALL be cleared when the next sweep starts.
REQ-025 Requests held during SWEEP SHALL stay unacknowledged; data is not dropped and must be held by the requester.

Reset
REQ-026 Reset SHALL set FSM IDLE, all state 0, all threshold THR_INIT, arbiter pointer 0, pending 0, spike_valid 0, spike_idx 0, busy 0.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep with no further spikes emitted.

Configuration
REQ-028 Macro EIF_LEAK_EN defined: non-spiking visited neuron SHALL additionally get state <= max(state - 1, 0) in the same cycle.
REQ-029 Macro EIF_LEAK_EN undefined: non-spiking neuron state SHALL be unchanged by the sweep.

Structure
REQ-030 Package eif_pkg SHALL hold the FSM state enum, the 8-bit state/threshold typedef and default constants THR_INIT, THR_MIN, THR_DEC.
REQ-031 Round-robin grant logic SHALL be a sub-module rr_arbiter (request vector in, one-hot grant out, pointer advance on accept).

Verification
REQ-032 Reset, no stimulus -> all req_ready 0, spike_valid never asserts over 100 cycles.
REQ-033 Requesters 0..3 all valid continuously, idx 0, current 1 -> grants cycle 0,1,2,3,0; state[0]=4 after 4 cycles.
REQ-034 Inject 255 then 10 into neuron 2 -> state[2]=255 (saturates); tick -> spike_valid with spike_idx=2 on sweep index 2, state[2]=55, threshold[2]=190.
REQ-035 tick twice during a sweep -> exactly one extra sweep, 16 busy cycles total, NUM_NEURONS=8.
REQ-036 Neuron below threshold, 5 ticks after one spike (threshold 190) -> threshold 195; with EIF_LEAK_EN and state 3, state reaches 0 and stays 0.
REQ-037 rst_n low at sweep index 4 with pending spikes -> no spike_valid, all registers at reset values next cycle.
